// File: rtl/muldiv_unit_if.sv
// Execute-stage to multiply/divide unit interface: request, MTHI/MTLO writes,
// status and the architectural HI/LO registers.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs, rt, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide over a shared 64-bit accumulator, results into HI/LO.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        is_div_q, neg_q, neg_r, dz_q;
    logic [31:0] mag;
    logic [63:0] acc;
    logic [31:0] hi_q, lo_q;
    logic        done_q, div_zero_q;

    logic        is_div, sgn, rt_zero;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] add_sum, sub_diff;
    logic [63:0] acc_nxt, prod;
    logic [31:0] quo, rem;

    always_comb begin
        is_div  = bus.op[1];
        sgn     = ~bus.op[0];
        rt_zero = (bus.rt == 32'd0);
        rs_mag  = (sgn && bus.rs[31]) ? -bus.rs : bus.rs;
        rt_mag  = (sgn && bus.rt[31]) ? -bus.rt : bus.rt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (is_div && rt_zero) ? FIN : CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; mag is multiplicand/divisor.
    always_comb begin
        add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
        sub_diff = acc[63:31] - {1'b0, mag};
        if (is_div_q)
            acc_nxt = sub_diff[32] ? {acc[62:0], 1'b0}
                                   : {sub_diff[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {add_sum, acc[31:1]};
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[31:0]  : acc[31:0];
        rem  = neg_r ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 5'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz_q       <= 1'b0;
            mag        <= 32'd0;
            acc        <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wr_data;
                    if (bus.wr_lo) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        is_div_q <= is_div;
                        mag      <= is_div ? rt_mag : rs_mag;
                        acc      <= {32'd0, is_div ? rs_mag : rt_mag};
                        neg_q    <= sgn & (bus.rs[31] ^ bus.rt[31]);
                        neg_r    <= sgn & bus.rs[31];
                        dz_q     <= is_div & rt_zero;
                        cnt      <= 5'd0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                end
                FIN: begin
                    done_q     <= 1'b1;
                    div_zero_q <= dz_q;
                    if (!dz_q) begin
                        if (is_div_q) begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end else begin
                            {hi_q, lo_q} <= prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO, DivZero and completion
// cycle are queued at Start and checked when Done pulses.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [63:0] res;
        bit          dz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, q, r;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        case (op)
            2'b00: return sa * sbv;
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Called right after a negedge; drives Start for one cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz  = op[1] && (b == 32'd0);
        e.res = e.dz ? 64'd0 : model(op, a, b);
        e.due = cyc + 1 + (e.dz ? 1 : 33);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
    endtask

    task automatic mt(input bit sel_hi, input logic [31:0] d);
        bus.wr_hi   = sel_hi;
        bus.wr_lo   = !sel_hi;
        bus.wr_data = d;
        if (sel_hi) m_hi = d;
        else        m_lo = d;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.dz) begin
                        chk("dz_hi", bus.hi, m_hi);
                        chk("dz_lo", bus.lo, m_lo);
                    end else begin
                        chk("hi", bus.hi, mon_e.res[63:32]);
                        chk("lo", bus.lo, mon_e.res[31:0]);
                        m_hi = mon_e.res[63:32];
                        m_lo = mon_e.res[31:0];
                    end
                    chk("div_zero", bus.div_zero, mon_e.dz);
                    chk("latency", cyc, mon_e.due);
                end
            end else begin
                chk("dz_idle", bus.div_zero, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.rs = 32'd0; bus.rt = 32'd0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 32'd0;

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        chk("busy_calc", bus.busy, 1);
        wait_idle();
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFEB);

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);

        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("divovf_lo", bus.lo, 32'h80000000);
        chk("divovf_hi", bus.hi, 32'h00000000);

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        chk("mthi", bus.hi, 32'h11);
        chk("mtlo", bus.lo, 32'h22);
        issue(2'b11, 32'd100, 32'd0);
        wait_idle();
        chk("dz0_hi", bus.hi, 32'h11);
        chk("dz0_lo", bus.lo, 32'h22);

        // abandon an operation at CALC count 10
        issue(2'b11, 32'd5000, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7);
        wait_idle();
        chk("post_rst_lo", bus.lo, 32'd14);
        chk("post_rst_hi", bus.hi, 32'd2);

        // Start/WrHI while busy ignored, then Start on the Done cycle
        issue(2'b00, 32'h12345678, 32'hFFFFFF00);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.rs = 32'd5; bus.rt = 32'd0;
        bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        chk("still_busy", bus.busy, 1);
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        chk("done_seen", bus.done, 1);
        issue(2'b11, 32'd1000, 32'd3);
        wait_idle();

        // MTHI together with Start writes now, result overwrites later
        bus.wr_hi = 1'b1; bus.wr_data = 32'hCAFE0001; m_hi = 32'hCAFE0001;
        issue(2'b01, 32'h00010000, 32'h00030000);
        chk("wr_with_start", bus.hi, 32'hCAFE0001);
        wait_idle();
        chk("overwrite_hi", bus.hi, 32'h00000003);

        for (int i = 0; i < 12; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) b = -b;
            issue(op, a, b);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
